alien_formation_ctrl: RTL and testbench

ALIEN_FORMATION_CTRL -- requirements
Module: alien_formation_ctrl

---
 rtl/alien_pkg.sv | 18 +
 rtl/alien_extent.sv | 50 +++++
 rtl/alien_formation_ctrl.sv | 137 +++++++++++++
 tb/tb_alien_formation_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// Shared definitions for the alien formation: grid geometry, default pixel
// pitches and the wave state encoding used by the controller and the renderer.
package alien_pkg;

  localparam int GRID_ROWS         = 4;
  localparam int GRID_COLS         = 9;
  localparam int NUM_ALIENS        = GRID_ROWS * GRID_COLS;
  localparam int ALIENS_WIDTH_DEF  = 20;
  localparam int ALIENS_HEIGHT_DEF = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    CLEARED = 2'd2,
    LANDED  = 2'd3
  } state_t;

endpackage

// File: rtl/alien_extent.sv
// Combinational extent finder: from the alive mask, derives the leftmost and
// rightmost occupied columns, the lowest occupied row and the live count.
module alien_extent
  import alien_pkg::*;
(
  input  logic [NUM_ALIENS-1:0] alive,
  output logic [3:0]            col_min,
  output logic [3:0]            col_max,
  output logic [1:0]            row_max,
  output logic [5:0]            pop_count
);

  logic [GRID_COLS-1:0] col_any;
  logic [GRID_ROWS-1:0] row_any;

  // Fold the mask into per-column / per-row occupancy and count live aliens.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    col_any   = '0;
    row_any   = '0;
    pop_count = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (alive[r*GRID_COLS + c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
          pop_count  = pop_count + 6'd1;
        end
      end
    end
  end

  // Pick the extreme occupied column/row indices; an empty mask reports zeros.
  always_comb begin
    col_min = '0;
    col_max = '0;
    row_max = '0;
    for (int c = GRID_COLS - 1; c >= 0; c--) begin
      if (col_any[c]) col_min = 4'(c);
    end
    for (int c = 0; c < GRID_COLS; c++) begin
      if (col_any[c]) col_max = 4'(c);
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (row_any[r]) row_max = 2'(r);
    end
  end

endmodule

// File: rtl/alien_formation_ctrl.sv
// Alien formation controller: marches the 4x9 formation left/right, drops it
// at the playfield edges, speeds up as aliens die, and reports win/loss.
module alien_formation_ctrl
  import alien_pkg::*;
#(
  parameter int ALIENS_WIDTH  = ALIENS_WIDTH_DEF,
  parameter int ALIENS_HEIGHT = ALIENS_HEIGHT_DEF,
  parameter int X_INIT        = 100,
  parameter int Y_INIT        = 40,
  parameter int STEP_X        = 4,
  parameter int STEP_Y        = 10,
  parameter int X_MIN         = 10,
  parameter int X_MAX         = 630,
  parameter int Y_LIMIT       = 400,
  parameter int PERIOD_MIN    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  frameTick,
  input  logic                  hitValid,
  input  logic [5:0]            hitIndex,
  output logic [9:0]            xAlien,
  output logic [9:0]            yAlien,
  output logic [NUM_ALIENS-1:0] alive,
  output logic                  dirRight,
  output logic                  stepPulse,
  output logic                  cleared,
  output logic                  landed
);

  localparam logic [10:0] W11      = 11'(ALIENS_WIDTH);
  localparam logic [10:0] H11      = 11'(ALIENS_HEIGHT);
  localparam logic [10:0] STEP_X11 = 11'(STEP_X);
  localparam logic [10:0] STEP_Y11 = 11'(STEP_Y);
  localparam logic [10:0] X_MIN11  = 11'(X_MIN);
  localparam logic [10:0] X_MAX11  = 11'(X_MAX);
  localparam logic [10:0] Y_LIM11  = 11'(Y_LIMIT);
  localparam logic [10:0] PIX_TOP  = 11'd1023;
  localparam logic [NUM_ALIENS-1:0] ONE_HOT0 = {{(NUM_ALIENS-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [6:0]              frame_cnt;
  logic [3:0]              col_min, col_max;
  logic [1:0]              row_max;
  logic [5:0]              pop_count;
  logic [6:0]              period;
  logic                    step_due;
  logic                    drop;
  logic [9:0]              x_step, y_step;
  logic                    land_hit;
  logic [NUM_ALIENS-1:0]   alive_next;

  // Extents and count always come from the registered (pre-hit) mask.
  alien_extent u_extent (
    .alive     (alive),
    .col_min   (col_min),
    .col_max   (col_max),
    .row_max   (row_max),
    .pop_count (pop_count)
  );

  // Step timing, edge tests (11-bit, saturating) and hit masking.
  always_comb begin
    logic [10:0] x_ext, y_drop, right_edge, left_edge, x_right, bottom;
    x_ext      = {1'b0, xAlien};
    period     = 7'(PERIOD_MIN) + {2'b00, pop_count[5:1]};
    step_due   = (state == MARCH) && frameTick && ((frame_cnt + 7'd1) >= period);
    right_edge = x_ext + W11 * {6'd0, col_max, 1'b1} + STEP_X11;
    left_edge  = x_ext + W11 * {6'd0, col_min, 1'b0};
    drop       = dirRight ? (right_edge > X_MAX11) : (left_edge < X_MIN11 + STEP_X11);
    x_right    = x_ext + STEP_X11;
    if (dirRight) x_step = (x_right > PIX_TOP) ? 10'h3FF : x_right[9:0];
    else          x_step = (x_ext < STEP_X11) ? 10'd0 : 10'(x_ext - STEP_X11);
    y_drop     = {1'b0, yAlien} + STEP_Y11;
    y_step     = (y_drop > PIX_TOP) ? 10'h3FF : y_drop[9:0];
    bottom     = {1'b0, y_step} + H11 * {8'd0, row_max, 1'b1};
    land_hit   = step_due && drop && (bottom >= Y_LIM11);
    alive_next = alive;
    if ((state == MARCH) && hitValid && (hitIndex < 6'(NUM_ALIENS)))
      alive_next = alive & ~(ONE_HOT0 << hitIndex);
  end

  // Wave FSM with all outputs registered; start reloads from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xAlien    <= 10'(X_INIT);
      yAlien    <= 10'(Y_INIT);
      alive     <= '0;
      dirRight  <= 1'b1;
      frame_cnt <= '0;
      stepPulse <= 1'b0;
      cleared   <= 1'b0;
      landed    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      stepPulse <= 1'b0;
      if (start) begin
        state     <= MARCH;
        xAlien    <= 10'(X_INIT);
        yAlien    <= 10'(Y_INIT);
        alive     <= '1;
        dirRight  <= 1'b1;
        frame_cnt <= '0;
        cleared   <= 1'b0;
        landed    <= 1'b0;
      end else begin
        case (state)
          MARCH: begin
            alive <= alive_next;
            if (frameTick) frame_cnt <= step_due ? 7'd0 : frame_cnt + 7'd1;
            if (step_due) begin
              stepPulse <= 1'b1;
              if (drop) begin
                yAlien   <= y_step;
                dirRight <= ~dirRight;
              end else begin
                xAlien <= x_step;
              end
            end
            if (alive_next == '0) begin
              state   <= CLEARED;
              cleared <= 1'b1;
            end else if (land_hit) begin
              state  <= LANDED;
              landed <= 1'b1;
            end
          end
          default: ; // IDLE, CLEARED, LANDED hold everything until start
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Testbench for alien_formation_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the wave rules.
module tb_alien_formation_ctrl;

  localparam int W = 20, H = 10, X_INIT = 100, Y_INIT = 40;
  localparam int STEP_X = 4, STEP_Y = 10, X_MIN = 10, X_MAX = 630;
  localparam int Y_LIMIT = 400, PERIOD_MIN = 2;
  localparam int M_IDLE = 0, M_MARCH = 1, M_CLEARED = 2, M_LANDED = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, frameTick, hitValid;
  logic [5:0]  hitIndex;
  logic [9:0]  xAlien, yAlien;
  logic [35:0] alive;
  logic        dirRight, stepPulse, cleared, landed;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int        m_mode, m_x, m_y, m_cnt;
  bit [35:0] m_alive;
  bit        m_dir, m_step, m_cleared, m_landed;

  alien_formation_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frameTick (frameTick),
    .hitValid  (hitValid),
    .hitIndex  (hitIndex),
    .xAlien    (xAlien),
    .yAlien    (yAlien),
    .alive     (alive),
    .dirRight  (dirRight),
    .stepPulse (stepPulse),
    .cleared   (cleared),
    .landed    (landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit col_live(int c);
    for (int r = 0; r < 4; r++) if (m_alive[r*9 + c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit row_live(int r);
    for (int c = 0; c < 9; c++) if (m_alive[r*9 + c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_period();
    return PERIOD_MIN + $countones(m_alive) / 2;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = X_INIT; m_y = Y_INIT; m_cnt = 0; m_alive = '0;
    m_dir = 1'b1; m_step = 1'b0; m_cleared = 1'b0; m_landed = 1'b0;
  endtask

  // One clock of the wave rules, applied to the model.
  task automatic model_step(input bit s, input bit t, input bit hv, input int hi);
    int  cmin, cmax, rmax;
    bit  step, drop, land;
    m_step = 1'b0;
    if (s) begin
      m_mode = M_MARCH; m_x = X_INIT; m_y = Y_INIT; m_alive = '1; m_dir = 1'b1;
      m_cnt = 0; m_cleared = 1'b0; m_landed = 1'b0;
    end else if (m_mode == M_MARCH) begin
      cmin = 0; cmax = 0; rmax = 0;
      for (int c = 8; c >= 0; c--) if (col_live(c)) cmin = c;
      for (int c = 0; c < 9; c++)  if (col_live(c)) cmax = c;
      for (int r = 0; r < 4; r++)  if (row_live(r)) rmax = r;
      step = 1'b0; land = 1'b0;
      if (t) begin
        if (m_cnt + 1 >= m_period()) begin m_cnt = 0; step = 1'b1; end
        else m_cnt++;
      end
      if (step) begin
        m_step = 1'b1;
        if (m_dir) drop = (m_x + W*(2*cmax + 1) + STEP_X > X_MAX);
        else       drop = (m_x + W*2*cmin < X_MIN + STEP_X);
        if (drop) begin
          m_y   = (m_y + STEP_Y > 1023) ? 1023 : m_y + STEP_Y;
          m_dir = !m_dir;
          land  = (m_y + H*(2*rmax + 1) >= Y_LIMIT);
        end else if (m_dir) m_x = (m_x + STEP_X > 1023) ? 1023 : m_x + STEP_X;
        else                m_x = (m_x < STEP_X) ? 0 : m_x - STEP_X;
      end
      if (hv && hi < 36) m_alive[hi] = 1'b0;
      if (m_alive == '0) begin m_mode = M_CLEARED; m_cleared = 1'b1; end
      else if (land)     begin m_mode = M_LANDED;  m_landed  = 1'b1; end
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {4'b0, xAlien, yAlien, alive, dirRight, stepPulse, cleared, landed};
  endfunction

  function automatic logic [63:0] model_vec();
    return {4'b0, 10'(m_x), 10'(m_y), m_alive, m_dir, m_step, m_cleared, m_landed};
  endfunction

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic cycle(input bit s, input bit t, input bit hv, input int hi);
    start = s; frameTick = t; hitValid = hv; hitIndex = 6'(hi);
    model_step(s, t, hv, hi);
    @(posedge clk); #1;
    check("cycle", dut_vec(), model_vec());
    start = 1'b0; frameTick = 1'b0; hitValid = 1'b0; hitIndex = '0;
  endtask

  initial begin
    int          n, pulses;
    logic [35:0] exp_mask;

    rst_n = 1'b0; start = 1'b0; frameTick = 1'b0; hitValid = 1'b0; hitIndex = '0;
    model_reset();
    #12;
    check("reset_vec", dut_vec(), model_vec());
    check("reset_x", xAlien, 100);
    check("reset_alive", alive, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores ticks and hits
    cycle(0, 1, 1, 3);
    cycle(0, 1, 0, 0);

    // Start, 20 frame ticks give exactly one step 100 -> 104
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    check("first_step_pulse", stepPulse, 1);
    check("first_step_x", xAlien, 104);
    check("first_step_y", yAlien, 40);

    // Full wave to the right edge: x + 20*17 + 4 > 630 first at x = 288
    for (int i = 0; i < 5000 && dirRight; i++) cycle(0, 1, 0, 0);
    check("full_drop_dir", dirRight, 0);
    check("full_drop_x", xAlien, 288);
    check("full_drop_y", yAlien, 50);

    // Kill columns 7 and 8: period 2+14 = 16, drop at x + 20*13 + 4 > 630 (x = 368)
    cycle(1, 0, 0, 0);
    for (int r = 0; r < 4; r++) for (int c = 7; c < 9; c++) cycle(0, 0, 1, r*9 + c);
    n = 0;
    for (int i = 0; i < 100 && !stepPulse; i++) begin cycle(0, 1, 0, 0); n++; end
    check("period_28_alive", n, 16);
    for (int i = 0; i < 5000 && dirRight; i++) cycle(0, 1, 0, 0);
    check("narrow_drop_x", xAlien, 368);
    check("narrow_drop_y", yAlien, 50);

    // Out-of-range hit ignored, repeated hit clears once, hit coincident with step
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 40);
    check("hit40_ignored", alive, 36'hF_FFFF_FFFF);
    cycle(0, 0, 1, 5);
    cycle(0, 0, 1, 5);
    exp_mask = 36'hF_FFFF_FFFF & ~(36'h1 << 5);
    check("hit5_twice", alive, exp_mask);
    for (int i = 0; i < 40 && m_cnt != m_period() - 1; i++) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 6);
    exp_mask = exp_mask & ~(36'h1 << 6);
    check("hit_step_pulse", stepPulse, 1);
    check("hit_step_alive", alive, exp_mask);
    check("hit_step_x", xAlien, 104);

    // Random traffic against the model
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 63)));

    // Kill all: cleared next cycle, motion stops, start reloads
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 36; i++) cycle(0, 0, 1, i);
    check("cleared_flag", cleared, 1);
    check("cleared_alive", alive, 0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin cycle(0, 1, 0, 0); if (stepPulse) pulses++; end
    check("cleared_no_step", pulses, 0);
    cycle(1, 0, 0, 0);
    check("reload_cleared", cleared, 0);
    check("reload_alive", alive, 36'hF_FFFF_FFFF);
    check("reload_x", xAlien, 100);

    // One alien at row 3 col 0: lands when y + 70 >= 400, i.e. y = 330
    for (int i = 0; i < 36; i++) if (i != 27) cycle(0, 0, 1, i);
    for (int i = 0; i < 20000 && !landed; i++) cycle(0, 1, 0, 0);
    check("landed_flag", landed, 1);
    check("landed_y", yAlien, 330);
    check("landed_not_cleared", cleared, 0);

    // Asynchronous reset in the middle of a march
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) cycle(0, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_vec", dut_vec(), model_vec());
    check("async_rst_y", yAlien, 40);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
